// File: rtl/nano6502_pkg.sv
// Shared nano6502 definitions: IO bank numbers, interrupt controller register
// offsets and interrupt source indices.
package nano6502_pkg;

  localparam logic [7:0] IOBANK_IRQ = 8'h07;

  localparam int IRQ_NSRC = 8;

  typedef enum logic [2:0] {
    IRQ_REG_PENDING = 3'd0,
    IRQ_REG_ENABLE  = 3'd1,
    IRQ_REG_MODE    = 3'd2,
    IRQ_REG_ACTIVE  = 3'd3,
    IRQ_REG_CTRL    = 3'd4,
    IRQ_REG_SET     = 3'd5,
    IRQ_REG_CURRENT = 3'd6,
    IRQ_REG_RSVD    = 3'd7
  } irq_reg_e;

  localparam int IRQ_SRC_UART   = 0;
  localparam int IRQ_SRC_TIMER  = 1;
  localparam int IRQ_SRC_USB    = 2;
  localparam int IRQ_SRC_SD     = 3;
  localparam int IRQ_SRC_VBLANK = 4;

  localparam int IRQ_CTRL_GIE = 0;
  localparam int IRQ_CTRL_IRQ = 1;

  // CURRENT register encoding: bit 7 flags a valid index in bits 2:0.
  function automatic logic [7:0] irq_current_code(input logic valid, input logic [2:0] idx);
    return valid ? {1'b1, 4'b0000, idx} : 8'h00;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder with a valid flag.
module irq_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    // Scan downward so the lowest set bit is the last assignment to stick.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// 65C02 interrupt controller: latches level/edge sources into PENDING and
// drives a registered, globally gated IRQ line.
module irq_controller
  import nano6502_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            R_W_n,
  input  logic [2:0]      reg_addr_i,
  input  logic [2:0]      reg_addr_r_i,
  input  logic [7:0]      data_i,
  input  logic            irq_cs,
  output logic [7:0]      data_o,
  input  logic [NSRC-1:0] src_i,
  output logic            irq_o
);

  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] en_q, en_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] src_q;
  logic            gie_q, gie_d;
  logic            irq_q, irq_d;
  logic [7:0]      rdata_q, rdata_d;

  logic            wr_stb;
  logic [NSRC-1:0] src_edge;
  logic [NSRC-1:0] sw_set;
  logic [NSRC-1:0] sw_clr;
  logic [NSRC-1:0] set_evt;
  logic [NSRC-1:0] active;
  logic [2:0]      cur_idx;
  logic            cur_valid;

  assign wr_stb   = irq_cs & ~R_W_n;
  assign src_edge = src_i & ~src_q;
  assign sw_set   = (wr_stb && reg_addr_i == IRQ_REG_SET)     ? data_i : '0;
  assign sw_clr   = (wr_stb && reg_addr_i == IRQ_REG_PENDING) ? data_i : '0;
  assign active   = pend_q & en_q;

  // Set always beats clear so an event coinciding with a W1C is never lost.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
    assign set_evt[gi] = (mode_q[gi] ? src_edge[gi] : src_i[gi]) | sw_set[gi];
    assign pend_d[gi]  = set_evt[gi] | (pend_q[gi] & ~sw_clr[gi]);
  end

  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    gie_d  = gie_q;
    if (wr_stb) begin
      case (reg_addr_i)
        IRQ_REG_ENABLE: en_d   = data_i;
        IRQ_REG_MODE:   mode_d = data_i;
        IRQ_REG_CTRL:   gie_d  = data_i[IRQ_CTRL_GIE];
        default: ;
      endcase
    end
  end

  assign irq_d = gie_q & (|active);

  irq_prio_enc #(
    .N (NSRC),
    .W (3)
  ) u_prio (
    .req_i   (active),
    .idx_o   (cur_idx),
    .valid_o (cur_valid)
  );

  // Read data reflects register state before any write landing this edge.
  always_comb begin
    rdata_d = 8'h00;
    case (reg_addr_r_i)
      IRQ_REG_PENDING: rdata_d = pend_q;
      IRQ_REG_ENABLE:  rdata_d = en_q;
      IRQ_REG_MODE:    rdata_d = mode_q;
      IRQ_REG_ACTIVE:  rdata_d = active;
      IRQ_REG_CTRL:    rdata_d = {6'b000000, irq_q, gie_q};
      IRQ_REG_CURRENT: rdata_d = irq_current_code(cur_valid, cur_idx);
      default:         rdata_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q  <= '0;
      en_q    <= '0;
      mode_q  <= '0;
      src_q   <= '0;
      gie_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      pend_q  <= pend_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      src_q   <= src_i;
      gie_q   <= gie_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_o = rdata_q;
  assign irq_o  = irq_q;

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller that turns peripheral interrupt requests into the single active-high IRQ input of the 65C02 core. It occupies IO bank 0x0007 in the 0xFE00–0xFEFF IO page, behind the address decoder's chip-select. It latches up to 8 level- or edge-triggered sources into a pending register and gates them with per-source and global enables. Firmware services sources in fixed priority order, using the CURRENT register to identify the next one.

## Interface
- `NSRC`, default 8: number of interrupt sources. Fixed at 8 for the register map.
- `clk_i` in, 1 bit: system clock, the CPU clock. Single clock domain.
- `rst_n_i` in, 1 bit: asynchronous, active-low reset.
- `R_W_n` in, 1 bit: registered CPU read/write flag; 0 means write.
- `reg_addr_i` in, 3 bits: registered write address (`cpu_addr_w[2:0]`).
- `reg_addr_r_i` in, 3 bits: unregistered read address (`cpu_addr[2:0]`).
- `data_i` in, 8 bits: CPU write data.
- `irq_cs` in, 1 bit: chip-select from the address decoder.
- `data_o` out, 8 bits: register read data.
- `src_i` in, 8 bits: interrupt sources, active high, synchronous to `clk_i`.
  - bit 0 UART RX, bit 1 timer, bit 2 USB HID, bit 3 SD, bit 4 video vblank, bits 7:5 spare (tied 0).
- `irq_o` out, 1 bit: to the `cpu_65c02` IRQ input, active high.

## Operation
Registers, selected by address [2:0]:
- 0 PENDING: R; write-1-to-clear.
- 1 ENABLE: R/W.
- 2 MODE: R/W. Per bit, 1 = rising-edge source, 0 = level-high source.
- 3 ACTIVE: R. Value is PENDING & ENABLE.
- 4 CTRL: R/W bit 0 GIE (global enable); bit 1 read-only, returns current `irq_o`; other bits read 0.
- 5 SET: W; write 1 sets the corresponding pending bits. Reads 0x00.
- 6 CURRENT: R. 0x80 | index of the lowest-numbered ACTIVE bit; 0x00 if none. Bit 0 has the highest priority.
- 7: reserved. Reads 0x00, writes ignored.

Behaviour:
- Write strobe: `irq_cs & ~R_W_n`, sampled at the rising edge. Uses `reg_addr_i` and `data_i`.
- Reads have no side effects.
- Edge detect: `src_d <= src_i` every cycle. Edge = `src_i & ~src_d`.
- Pending update per bit, every cycle: `pend_next = set_evt | (pend & ~clr)`.
  - `set_evt` = edge (MODE=1), or `src_i` high (MODE=0), or a SET-register write bit.
  - `clr` = a PENDING write-1 bit.
- `irq_o <= GIE & |(PENDING & ENABLE)`, registered.
- Reset values:
  - PENDING, ENABLE, MODE, CTRL, `src_d`: 0x00.
  - `data_o`: 0x00. `irq_o`: 0.

Boundary conditions:
- A set event and a clear of the same bit in the same cycle: set wins, bit stays 1.
- Level source still high after a W1C: bit re-pends at the next edge, so firmware must quiet the peripheral first.
- Source already high when reset releases: because `src_d` resets to 0, this counts as an edge (MODE=1) and pends. ENABLE=0 masks it. Firmware clears PENDING before enabling.
- MODE change: PENDING is not altered. Only future set events follow the new mode.
- Clearing ENABLE or GIE: `irq_o` drops one cycle later; PENDING is kept.
- Reset asserted mid-operation: all state clears immediately (asynchronous). `irq_o` goes to 0 without waiting for a clock.

## Timing
- Source to pending: a source first sampled high at edge k sets pending at edge k.
- Pending to IRQ: `irq_o` rises at edge k+1. Total latency from source to `irq_o` is 2 edges.
- W1C or ENABLE/GIE write at edge k: `irq_o` falls at edge k+1 if nothing remains active.
- Read latency: `data_o` is registered from `reg_addr_r_i` each cycle, valid one cycle after the address. This matches the CPU's synchronous-RAM read timing.
  - A read in the cycle of a write returns the pre-write value.

## Structure
- Shared package `nano6502_pkg` holds:
  - IO bank constant `IOBANK_IRQ = 8'h07`.
  - Register offsets `IRQ_REG_PENDING` … `IRQ_REG_CURRENT`.
  - Source indices `IRQ_SRC_UART` … `IRQ_SRC_VBLANK`.
- Sub-module `irq_prio_enc`: combinational 8-to-3 lowest-index priority encoder with a valid flag. Used to form CURRENT.
- Top-level integration:
  - Address decoder gains `irq_cs` for bank 0x0007.
  - Read-data mux gains an `irq_cs` leg.
  - `cpu_65c02` IRQ input is wired to `irq_o`.

## Test plan
- Reset, then read all registers: every register 0x00, `irq_o`=0. Assert `rst_n_i` low mid-IRQ: `irq_o` drops asynchronously.
- Level source: MODE=0x00, ENABLE=0x02, CTRL=0x01, hold `src_i[1]` high.
  - `irq_o`=1 two edges after the source. CURRENT=0x81.
  - W1C 0x02 while the source is still high: PENDING stays 0x02.
  - Drop the source, then W1C: `irq_o`=0.
- Edge source: MODE=0x01, pulse `src_i[0]` for 1 cycle: PENDING=0x01. Hold it high for 10 cycles: there is no second set after the W1C.
- Priority: SET write 0x14 with ENABLE=0xFF: CURRENT=0x82. W1C 0x04: CURRENT=0x84. W1C 0x10: CURRENT=0x00, `irq_o`=0.
- Simultaneous events: edge on bit 3 in the same cycle as W1C 0x08: PENDING bit 3 remains 1.
- Masking: PENDING=0x01 with GIE=0: `irq_o`=0 and ACTIVE=0x01. Set GIE: `irq_o`=1 one cycle later.
